// File: rtl/serializador_tx.sv
// serializador_tx: byte-to-serial transmitter with link synchronisation.
// A free-running 3-bit bit counter marks a load edge once every 8 clocks.
// After reset the block sends N_SYNC COM symbols and then enters ACTIVE.
// In ACTIVE it sends data_in when valid_in is high and COM (idle) when it is low.
//
// Ports:
//   clk_32f  - serial bit clock, 8x the byte rate
//   reset_L  - asynchronous active-low reset
//   data_in  - byte from the upstream mux, sampled only on load edges
//   valid_in - data_in qualifier, sampled only on load edges
//   data_out - serial line, MSB first
//   rdy      - one-cycle strobe, high during the cycle before each load edge
//   active   - high once link sync is complete
module serializador_tx (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_out,
  output logic       rdy,
  output logic       active
);

  localparam logic [7:0] Com   = 8'hBC;
  localparam logic [2:0] NSync = 3'd4;

  typedef enum logic [0:0] {StSync, StActive} state_e;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q;
  logic [2:0] com_cnt_q, com_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rdy_q;
  logic       load;

  // Reset leaves bit_cnt at 7, so the first edge after release is a load edge.
  assign load = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    shift_d   = {shift_q[6:0], 1'b0};
    if (load) begin
      unique case (state_q)
        StSync: begin
          shift_d = Com;
          if (com_cnt_q != NSync) begin
            com_cnt_d = com_cnt_q + 3'd1;
          end
          if (com_cnt_q == NSync - 3'd1) begin
            state_d = StActive;
          end
        end
        StActive: begin
          // COM bytes in the payload go out unmodified; no escaping.
          shift_d = valid_in ? data_in : Com;
        end
      endcase
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= StSync;
      bit_cnt_q <= 3'd7;
      com_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_q + 3'd1;
      com_cnt_q <= com_cnt_d;
      shift_q   <= shift_d;
      rdy_q     <= (bit_cnt_q == 3'd6);
    end
  end

  assign data_out = shift_q[7];
  assign rdy      = rdy_q;
  assign active   = (state_q == StActive);

endmodule

// File: tb/tb_serializador_tx.sv
// Testbench for serializador_tx: fixed vector table for sync/first payload, hand
// sequences for back-to-back bytes and mid-byte reset, and randomized traffic
// checked against a byte-level reference model.
module tb_serializador_tx;

  logic       clk_32f;
  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in;
  logic       data_out;
  logic       rdy;
  logic       active;

  serializador_tx dut (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .data_in (data_in),
    .valid_in(valid_in),
    .data_out(data_out),
    .rdy     (rdy),
    .active  (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state: edges since reset release, bytes loaded, current byte.
  int         edge_n;
  int         loads;
  logic [7:0] cur_byte;
  logic       exp_out;
  logic       exp_rdy;
  logic       exp_act;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       exp_out;
    logic       exp_rdy;
    logic       exp_act;
  } vec_t;

  vec_t tbl[40];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
  endtask

  task automatic model_reset();
    edge_n   = 0;
    loads    = 0;
    cur_byte = 8'h00;
  endtask

  // Drive inputs on the falling edge, advance one rising edge, update model, settle.
  task automatic tick(input logic v, input logic [7:0] d);
    int pos;
    @(negedge clk_32f);
    valid_in = v;
    data_in  = d;
    @(posedge clk_32f);
    edge_n++;
    pos = (edge_n - 1) % 8;
    if (pos == 0) begin
      cur_byte = (loads >= 4 && v) ? d : 8'hBC;
      loads++;
    end
    exp_out = cur_byte[7-pos];
    exp_rdy = (edge_n % 8 == 0);
    exp_act = (loads >= 4);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_out"}, {31'd0, data_out}, {31'd0, exp_out});
    check({tag, "_rdy"}, {31'd0, rdy}, {31'd0, exp_rdy});
    check({tag, "_act"}, {31'd0, active}, {31'd0, exp_act});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out"}, {31'd0, data_out}, 32'd0);
    check({tag, "_rdy"}, {31'd0, rdy}, 32'd0);
    check({tag, "_act"}, {31'd0, active}, 32'd0);
  endtask

  // Release just after a rising edge so the next tick() lands on edge 1.
  task automatic release_reset();
    repeat (2) @(posedge clk_32f);
    #1;
    reset_L = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [7:0]  com_b;
    logic [7:0]  a5_b;
    logic [7:0]  byte_v;
    logic [15:0] bits16;
    logic [31:0] bits32;

    com_b    = 8'hBC;
    a5_b     = 8'hA5;
    valid_in = 1'b0;
    data_in  = 8'h00;
    reset_L  = 1'b1;
    model_reset();

    // Table: 4 COM bytes (valid_in=1 with 0x55 during SYNC is ignored), then 0xA5
    // at edge 33 with inputs toggling on the following non-load edges.
    for (int i = 0; i < 40; i++) begin
      int e;
      e = i + 1;
      tbl[i].valid = 1'b0;
      tbl[i].data  = 8'h00;
      if (e == 9 || e == 17) begin
        tbl[i].valid = 1'b1;
        tbl[i].data  = 8'h55;
      end
      if (e == 33) begin
        tbl[i].valid = 1'b1;
        tbl[i].data  = 8'hA5;
      end
      if (e > 33) begin
        tbl[i].valid = e[0];
        tbl[i].data  = 8'($urandom);
      end
      byte_v         = (e >= 33) ? a5_b : com_b;
      tbl[i].exp_out = byte_v[7-((e-1)%8)];
      tbl[i].exp_rdy = (e % 8 == 0);
      tbl[i].exp_act = (e >= 25);
    end

    // Asynchronous reset before any clock edge.
    #1 reset_L = 1'b0;
    #1 check_zero("reset_async");
    release_reset();

    for (int i = 0; i < 40; i++) begin
      tick(tbl[i].valid, tbl[i].data);
      check($sformatf("tbl%0d_out", i), {31'd0, data_out}, {31'd0, tbl[i].exp_out});
      check($sformatf("tbl%0d_rdy", i), {31'd0, rdy}, {31'd0, tbl[i].exp_rdy});
      check($sformatf("tbl%0d_act", i), {31'd0, active}, {31'd0, tbl[i].exp_act});
    end

    // 0xFF then idle at the next load: 11111111 then 10111100.
    bits16 = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      tick(i == 0, 8'hFF);
      bits16 = {bits16[14:0], data_out};
      check_model("ff_seq");
    end
    check("ff_then_com", {16'd0, bits16}, 32'h0000_FFBC);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 200; i++) begin
      tick(1'($urandom_range(0, 1)), 8'($urandom));
      check_model("rand");
    end

    // Mid-byte reset after edge 36 while sending 0xFF.
    reset_L = 1'b0;
    #1 check_zero("reset2");
    release_reset();
    for (int i = 0; i < 36; i++) begin
      tick(1'b1, 8'hFF);
      check_model("pre_abort");
    end
    check("pre_abort_line", {31'd0, data_out}, 32'd1);
    #2 reset_L = 1'b0;
    #1 check_zero("abort");
    release_reset();
    bits32 = 32'd0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 8'($urandom));
      if (i < 32) bits32 = {bits32[30:0], data_out};
      check_model("post_abort");
    end
    check("post_abort_sync", bits32, 32'hBCBC_BCBC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
